// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, vectors and field positions.
// Build option: CP0_BD_EN enables branch-delay-slot capture (Cause.BD, EPC = PC-4).
package cp0_unit_pkg;

    localparam logic [31:0] PRID_VALUE = 32'h2025_0707;
    localparam int unsigned HW_INT_W   = 6;

    localparam logic [4:0] SR_NUM    = 5'd12;
    localparam logic [4:0] CAUSE_NUM = 5'd13;
    localparam logic [4:0] EPC_NUM   = 5'd14;
    localparam logic [4:0] PRID_NUM  = 5'd15;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam logic [31:0] TRAPPED_ADDRESS = 32'h0000_4180;
    localparam logic [31:0] INITIAL_ADDRESS = 32'h0000_3000;

    // Field positions inside SR and Cause
    localparam int unsigned SR_IM_HI  = 15;
    localparam int unsigned SR_IM_LO  = 10;
    localparam int unsigned SR_EXL    = 1;
    localparam int unsigned SR_IE     = 0;
    localparam int unsigned CAUSE_BD  = 31;
    localparam int unsigned CAUSE_IP_HI = 15;
    localparam int unsigned CAUSE_IP_LO = 10;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_EXC_LO = 2;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, mfc0/mtc0/eret, interrupt vs exception arbitration.
// Build option: CP0_BD_EN captures Cause.BD and backs EPC up to the branch for delay-slot victims.
module cp0_unit
    import cp0_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          A1,
    input  logic [4:0]          A2,
    input  logic [31:0]         DIn,
    input  logic                WE,
    input  logic                EXLClr,
    input  logic [31:0]         PC,
    input  logic                BDIn,
    input  logic [4:0]          ExcCodeIn,
    input  logic [HW_INT_W-1:0] HWInt,
    output logic                IntReq,
    output logic [31:0]         EPCOut,
    output logic [31:0]         DOut
);

    logic [HW_INT_W-1:0] im;
    logic                exl;
    logic                ie;
    logic                bd;
    logic [HW_INT_W-1:0] ip;
    logic [4:0]          exc_code;
    logic [31:0]         epc;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] epc_victim;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_pend = (|(HWInt & im)) & ie & ~exl;
    assign exc_pend = (ExcCodeIn != 5'd0) & ~exl;
    assign IntReq   = (int_pend | exc_pend) & ~reset;

`ifdef CP0_BD_EN
    assign epc_victim = (BDIn ? (PC - 32'd4) : PC) & ~32'd3;
`else
    logic unused_bdin;
    assign unused_bdin = BDIn;
    assign epc_victim  = PC & ~32'd3;
`endif

    assign sr_val    = {16'd0, im, 8'd0, exl, ie};
    assign cause_val = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
    assign EPCOut    = epc;

    // mfc0 read mux
    always_comb begin
        DOut = 32'd0;
        case (A1)
            SR_NUM:    DOut = sr_val;
            CAUSE_NUM: DOut = cause_val;
            EPC_NUM:   DOut = epc;
            PRID_NUM:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

    // Taking a trap discards any mtc0/eret in M, since that instruction is flushed
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl      <= 1'b1;
                epc      <= epc_victim;
                exc_code <= int_pend ? EXC_INT : ExcCodeIn;
`ifdef CP0_BD_EN
                bd       <= BDIn;
`else
                bd       <= 1'b0;
`endif
            end else begin
                if (WE && A2 == SR_NUM) begin
                    im  <= DIn[SR_IM_HI:SR_IM_LO];
                    exl <= DIn[SR_EXL];
                    ie  <= DIn[SR_IE];
                end
                if (WE && A2 == EPC_NUM) begin
                    epc <= DIn & ~32'd3;
                end
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (expectations follow CP0_BD_EN when defined).
module tb_cp0_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        WE, EXLClr;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPCOut, DOut;

    int n_cmp = 0;
    int n_bad = 0;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .EXLClr(EXLClr), .PC(PC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

`ifdef CP0_BD_EN
    localparam logic [31:0] EXP_EPC_OV    = 32'h0000_3020;
    localparam logic [31:0] EXP_CAUSE_OV  = 32'h8000_0030;
    localparam logic [31:0] EXP_EPC_WRAP  = 32'hFFFF_FFFC;
`else
    localparam logic [31:0] EXP_EPC_OV    = 32'h0000_3024;
    localparam logic [31:0] EXP_CAUSE_OV  = 32'h0000_0030;
    localparam logic [31:0] EXP_EPC_WRAP  = 32'h0000_0000;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] num, input logic [31:0] exp);
        A1 = num;
        #1;
        check(tag, DOut, exp);
    endtask

    initial begin
        reset = 1'b1; A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; EXLClr = 1'b0;
        PC = 32'h0000_3000; BDIn = 1'b0; ExcCodeIn = 5'd5; HWInt = 6'd0;
        tick(); tick();
        check("intreq_in_reset", {31'd0, IntReq}, 32'd0);
        rd("prid_in_reset", 5'd15, 32'h2025_0707);

        // Reset values
        reset = 1'b0; ExcCodeIn = 5'd0;
        rd("sr_reset", 5'd12, 32'd0);
        rd("cause_reset", 5'd13, 32'd0);
        rd("epc_reset", 5'd14, 32'd0);
        rd("prid", 5'd15, 32'h2025_0707);
        rd("other_reg", 5'd3, 32'd0);
        check("epcout_reset", EPCOut, 32'd0);
        check("intreq_idle", {31'd0, IntReq}, 32'd0);

        // mtc0 SR, then hardware interrupt
        WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
        tick();
        WE = 1'b0;
        rd("sr_written", 5'd12, 32'h0000_FC01);
        HWInt = 6'b000100; PC = 32'h0000_3010;
        #1;
        check("intreq_hwint", {31'd0, IntReq}, 32'd1);
        tick();
        check("intreq_after_int", {31'd0, IntReq}, 32'd0);
        rd("epc_int", 5'd14, 32'h0000_3010);
        rd("sr_exl", 5'd12, 32'h0000_FC03);
        rd("cause_int", 5'd13, 32'h0000_1000);

        // Pending interrupt fires after eret clears EXL
        tick();
        check("intreq_masked_exl", {31'd0, IntReq}, 32'd0);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        rd("sr_after_eret", 5'd12, 32'h0000_FC01);
        check("intreq_after_eret", {31'd0, IntReq}, 32'd1);
        PC = 32'h0000_3040;
        tick();
        HWInt = 6'd0;
        check("epcout_reint", EPCOut, 32'h0000_3040);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        check("intreq_quiet", {31'd0, IntReq}, 32'd0);

        // Overflow exception in a delay slot
        ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
        #1;
        check("intreq_exc", {31'd0, IntReq}, 32'd1);
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        rd("epc_ov", 5'd14, EXP_EPC_OV);
        rd("cause_ov", 5'd13, EXP_CAUSE_OV);

        // mtc0 SR while EXL=1, masked bits ignored
        WE = 1'b1; A2 = 5'd12; DIn = 32'hFFFF_FFFE;
        tick();
        rd("sr_mask", 5'd12, 32'h0000_FC02);
        DIn = 32'h0000_FC01;
        tick();
        WE = 1'b0;
        rd("sr_exl_clear", 5'd12, 32'h0000_FC01);

        // Interrupt + exception + mtc0 EPC in one cycle
        HWInt = 6'b000001; ExcCodeIn = 5'd10; PC = 32'h0000_3100;
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000;
        #1;
        check("intreq_both", {31'd0, IntReq}, 32'd1);
        tick();
        WE = 1'b0; HWInt = 6'd0; ExcCodeIn = 5'd0;
        rd("epc_mtc0_discarded", 5'd14, 32'h0000_3100);
        rd("cause_int_wins", 5'd13, 32'h0000_0400);

        // EPC low bits cleared; Cause not writable
        WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_3007;
        tick();
        check("epcout_aligned", EPCOut, 32'h0000_3004);
        A2 = 5'd13; DIn = 32'hFFFF_FFFF;
        tick();
        WE = 1'b0;
        rd("cause_readonly", 5'd13, 32'h0000_0000);

        // PC-4 wraps for a delay-slot victim at address 0
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCodeIn = 5'd4; BDIn = 1'b1; PC = 32'h0000_0000;
        tick();
        ExcCodeIn = 5'd0; BDIn = 1'b0;
        check("epc_wrap", EPCOut, EXP_EPC_WRAP);

        // Reset mid-handler
        HWInt = 6'b111111;
        reset = 1'b1;
        #1;
        check("intreq_reset_high", {31'd0, IntReq}, 32'd0);
        tick();
        reset = 1'b0; HWInt = 6'd0;
        rd("sr_midreset", 5'd12, 32'd0);
        rd("cause_midreset", 5'd13, 32'd0);
        rd("epc_midreset", 5'd14, 32'd0);
        check("epcout_midreset", EPCOut, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
